// File: rtl/synth_pkg.sv
// Shared definitions for the synth oscillator chain: sequencer states,
// default field widths and the packed table entry layout.
package synth_pkg;

  localparam int unsigned FREQ_W_DEF = 16;
  localparam int unsigned DUR_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StGap  = 2'd2
  } seq_state_e;

  // Table entry layout: frequency word in the upper bits, duration in the lower bits.
  typedef struct packed {
    logic [FREQ_W_DEF-1:0] freq;
    logic [DUR_W_DEF-1:0]  dur;
  } seq_entry_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Control, table-write and output bundle of the note sequencer.
interface note_sequencer_if #(
  parameter int unsigned STEPS  = 8,
  parameter int unsigned FREQ_W = 16,
  parameter int unsigned DUR_W  = 8
) ();

  localparam int unsigned IDX_W = $clog2(STEPS);

  logic              start;
  logic              stop;
  logic              loop_en;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [FREQ_W-1:0] wr_freq;
  logic [DUR_W-1:0]  wr_dur;
  logic [FREQ_W-1:0] freq;
  logic              gate;
  logic [IDX_W-1:0]  step_idx;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur,
    input  freq, gate, step_idx, busy, done
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur,
    output freq, gate, step_idx, busy, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high in the last count.
// clr forces the count back to 0 on the next edge.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12000
) (
  input  logic clk12MHz,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Count up, wrapping on the tick cycle or restarting on clr.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: walks a programmable note table, emitting a frequency
// word and gate per step with a fixed silent gap between notes.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned STEPS     = 8,
  parameter int unsigned TICK_DIV  = 12000,
  parameter int unsigned GAP_TICKS = 5,
  parameter int unsigned FREQ_W    = FREQ_W_DEF,
  parameter int unsigned DUR_W     = DUR_W_DEF
) (
  input logic             clk12MHz,
  input logic             rst,
  note_sequencer_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(STEPS);
  localparam int unsigned ENTRY_W = FREQ_W + DUR_W;
  localparam int unsigned GAP_W   = $clog2(GAP_TICKS + 1);

  logic [ENTRY_W-1:0] table_q [STEPS];

  seq_state_e        state_q;
  logic [FREQ_W-1:0] freq_q;
  logic              gate_q;
  logic [IDX_W-1:0]  step_idx_q;
  logic              busy_q;
  logic              done_q;
  logic [DUR_W-1:0]  remain_q;
  logic [GAP_W-1:0]  gap_q;

  logic              tick;
  logic              clr;
  logic              load_en;
  logic              end_pat;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W:0]    next_idx_w;
  logic [IDX_W-1:0]  next_idx;
  logic              last_step;
  logic [DUR_W-1:0]  dur0;
  logic [DUR_W-1:0]  next_dur;
  logic [FREQ_W-1:0] load_freq;
  logic [DUR_W-1:0]  load_dur;

  assign next_idx_w = {1'b0, step_idx_q} + (IDX_W + 1)'(1);
  assign next_idx   = next_idx_w[IDX_W-1:0];
  assign last_step  = (next_idx_w == (IDX_W + 1)'(STEPS));
  assign dur0       = table_q[0][DUR_W-1:0];
  assign next_dur   = table_q[next_idx][DUR_W-1:0];
  assign load_freq  = table_q[load_idx][ENTRY_W-1:DUR_W];
  assign load_dur   = table_q[load_idx][DUR_W-1:0];

  // Prescaler is held at 0 while idle and restarted on every step load.
  assign clr = load_en || (state_q == StIdle);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk12MHz (clk12MHz),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick)
  );

  // Table writes are accepted in any state; one-cycle write latency.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      for (int i = 0; i < int'(STEPS); i++) begin
        table_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      table_q[bus.wr_addr] <= {bus.wr_freq, bus.wr_dur};
    end
  end

  // Decide whether this edge loads a step or ends the pattern.
  always_comb begin
    load_en  = 1'b0;
    load_idx = '0;
    end_pat  = 1'b0;
    if (!bus.stop) begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            // An empty first entry ends at once even with looping on.
            if (dur0 != '0) load_en = 1'b1;
            else            end_pat = 1'b1;
          end
        end
        StGap: begin
          if (tick && (gap_q == GAP_W'(1))) begin
            if (!last_step && (next_dur != '0)) begin
              load_en  = 1'b1;
              load_idx = next_idx;
            end else if (bus.loop_en && (dur0 != '0)) begin
              load_en = 1'b1;
            end else begin
              end_pat = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Main FSM with registered outputs and note/gap counters.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state_q    <= StIdle;
      freq_q     <= '0;
      gate_q     <= 1'b0;
      step_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      remain_q   <= '0;
      gap_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q    <= StIdle;
        gate_q     <= 1'b0;
        step_idx_q <= '0;
        busy_q     <= 1'b0;
      end else if (load_en) begin
        state_q    <= StPlay;
        freq_q     <= load_freq;
        remain_q   <= load_dur;
        gate_q     <= (load_freq != '0);
        step_idx_q <= load_idx;
        busy_q     <= 1'b1;
      end else if (end_pat) begin
        state_q    <= StIdle;
        gate_q     <= 1'b0;
        step_idx_q <= '0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
      end else if ((state_q == StPlay) && tick) begin
        if (remain_q == DUR_W'(1)) begin
          gate_q  <= 1'b0;
          gap_q   <= GAP_W'(GAP_TICKS);
          state_q <= StGap;
        end else begin
          remain_q <= remain_q - DUR_W'(1);
        end
      end else if ((state_q == StGap) && tick) begin
        gap_q <= gap_q - GAP_W'(1);
      end
    end
  end

  assign bus.freq     = freq_q;
  assign bus.gate     = gate_q;
  assign bus.step_idx = step_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1.
module tb_note_sequencer;

  logic clk12MHz = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  note_sequencer_if #(.STEPS(8), .FREQ_W(16), .DUR_W(8)) bus ();

  note_sequencer #(
    .STEPS     (8),
    .TICK_DIV  (4),
    .GAP_TICKS (1),
    .FREQ_W    (16),
    .DUR_W     (8)
  ) dut (
    .clk12MHz (clk12MHz),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk12MHz = ~clk12MHz;

  task automatic step();
    @(posedge clk12MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check n consecutive busy cycles with fixed gate/freq/step_idx.
  task automatic seg(input string tag, input logic g, input int f, input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".gate"}, 32'(bus.gate), 32'(g));
      chk({tag, ".freq"}, 32'(bus.freq), f);
      chk({tag, ".idx"},  32'(bus.step_idx), idx);
      chk({tag, ".busy"}, 32'(bus.busy), 1);
      chk({tag, ".done"}, 32'(bus.done), 0);
      step();
    end
  endtask

  task automatic wr(input int addr, input int f, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_freq = 16'(f);
    bus.wr_dur  = 8'(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic chk_end(input string tag);
    chk({tag, ".done"}, 32'(bus.done), 1);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".gate"}, 32'(bus.gate), 0);
    chk({tag, ".idx"},  32'(bus.step_idx), 0);
    step();
    chk({tag, ".done_clr"}, 32'(bus.done), 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_freq = '0;
    bus.wr_dur  = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst.freq", 32'(bus.freq), 0);
    chk("rst.gate", 32'(bus.gate), 0);
    chk("rst.idx",  32'(bus.step_idx), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);

    // Basic two-note pattern
    wr(0, 441, 2);
    wr(1, 882, 1);
    wr(2, 0, 0);
    pulse_start();
    seg("t1.n0", 1'b1, 441, 0, 8);
    seg("t1.g0", 1'b0, 441, 0, 4);
    seg("t1.n1", 1'b1, 882, 1, 4);
    seg("t1.g1", 1'b0, 882, 1, 4);
    chk_end("t1.end");

    // Looping, then loop_en dropped mid-pattern
    bus.loop_en = 1'b1;
    pulse_start();
    seg("t2.n0", 1'b1, 441, 0, 8);
    seg("t2.g0", 1'b0, 441, 0, 4);
    seg("t2.n1", 1'b1, 882, 1, 4);
    seg("t2.g1", 1'b0, 882, 1, 4);
    seg("t2.l0a", 1'b1, 441, 0, 4);
    bus.loop_en = 1'b0;
    seg("t2.l0b", 1'b1, 441, 0, 4);
    seg("t2.lg0", 1'b0, 441, 0, 4);
    seg("t2.l1", 1'b1, 882, 1, 4);
    seg("t2.lg1", 1'b0, 882, 1, 4);
    chk_end("t2.end");

    // Rest entry between notes
    wr(1, 0, 3);
    wr(2, 882, 1);
    wr(3, 0, 0);
    pulse_start();
    seg("t3.n0", 1'b1, 441, 0, 8);
    seg("t3.g0", 1'b0, 441, 0, 4);
    seg("t3.rest", 1'b0, 0, 1, 12);
    seg("t3.g1", 1'b0, 0, 1, 4);
    seg("t3.n2", 1'b1, 882, 2, 4);
    seg("t3.g2", 1'b0, 882, 2, 4);
    chk_end("t3.end");

    // Stop during step 1, then start+stop together
    wr(1, 882, 1);
    wr(2, 0, 0);
    pulse_start();
    seg("t4.n0", 1'b1, 441, 0, 8);
    seg("t4.g0", 1'b0, 441, 0, 4);
    seg("t4.n1", 1'b1, 882, 1, 2);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("t4.stop.busy", 32'(bus.busy), 0);
    chk("t4.stop.gate", 32'(bus.gate), 0);
    chk("t4.stop.idx",  32'(bus.step_idx), 0);
    chk("t4.stop.done", 32'(bus.done), 0);
    chk("t4.stop.freq", 32'(bus.freq), 882);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4.after.done", 32'(bus.done), 0);
      chk("t4.after.busy", 32'(bus.busy), 0);
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("t4.both.busy", 32'(bus.busy), 0);
    chk("t4.both.gate", 32'(bus.gate), 0);
    chk("t4.both.done", 32'(bus.done), 0);
    step();
    chk("t4.both2.busy", 32'(bus.busy), 0);

    // Rewrite entry 1 while it plays
    bus.loop_en = 1'b1;
    pulse_start();
    seg("t5.n0", 1'b1, 441, 0, 8);
    seg("t5.g0", 1'b0, 441, 0, 4);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_freq = 16'd1000;
    bus.wr_dur  = 8'd1;
    seg("t5.n1a", 1'b1, 882, 1, 1);
    bus.wr_en = 1'b0;
    seg("t5.n1b", 1'b1, 882, 1, 3);
    seg("t5.g1", 1'b0, 882, 1, 4);
    seg("t5.l0", 1'b1, 441, 0, 8);
    seg("t5.lg0", 1'b0, 441, 0, 4);
    seg("t5.l1", 1'b1, 1000, 1, 4);
    bus.loop_en = 1'b0;
    seg("t5.lg1", 1'b0, 1000, 1, 4);
    chk_end("t5.end");

    // Reset mid-PLAY clears outputs and table
    pulse_start();
    seg("t6.n0", 1'b1, 441, 0, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.rst.freq", 32'(bus.freq), 0);
    chk("t6.rst.gate", 32'(bus.gate), 0);
    chk("t6.rst.idx",  32'(bus.step_idx), 0);
    chk("t6.rst.busy", 32'(bus.busy), 0);
    chk("t6.rst.done", 32'(bus.done), 0);
    step();
    chk("t6.rst2.busy", 32'(bus.busy), 0);
    pulse_start();
    chk_end("t6.empty");
    chk("t6.empty.gate", 32'(bus.gate), 0);

    // Empty table with looping still ends with done
    bus.loop_en = 1'b1;
    pulse_start();
    chk_end("t6.emptyloop");
    chk("t6.emptyloop.gate", 32'(bus.gate), 0);
    bus.loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
